pc_if_stage: RTL and testbench
==============================

Name: pc_if_stage

Overview:
- Instruction-fetch front end of the OpenMIPS pipeline: holds the program counter and drives chip-enable and address into the combinational instruction ROM.
- Registers the returned word, together with its PC, into the IF/ID pipeline register for the decode stage.
- Handles the pipeline stall vector, branch redirect from ID, exception flush from the control unit, and detection of misaligned fetch addresses.

Parameters:
- RESET_PC, 32'h00000000, PC value held during and immediately after reset.
- ADDR_W, 32, PC and ROM address width.
- INST_W, 32, instruction width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- stall_i  in  6  pipeline stall vector; bit0 = PC stage, bit1 = IF/ID, bit2 = ID; bits 5:3 unused here.
- flush_i  in  1  exception flush from the control unit.
- new_pc_i  in  ADDR_W  exception handler address, used with flush_i.
- branch_flag_i  in  1  taken branch/jump resolved in ID.
- branch_target_i  in  ADDR_W  branch/jump target.
- inst_i  in  INST_W  instruction word from the ROM, valid in the same cycle as rom_addr_o.
- rom_ce_o  out  1  ROM chip enable.
- rom_addr_o  out  ADDR_W  ROM byte address, equal to the PC register.
- id_pc_o  out  ADDR_W  PC of the instruction presented to ID.
- id_inst_o  out  INST_W  instruction presented to ID.
- id_adel_o  out  1  address-error-on-fetch flag for that instruction.
- id_valid_o  out  1  1 = id_* holds a real fetched instruction; 0 = bubble.

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_PC, rom_ce_o=0, id_pc_o=0, id_inst_o=0, id_adel_o=0, id_valid_o=0.
- Two-state control:
  - S_IDLE: entered on reset; rom_ce_o=0.
  - S_IDLE -> S_RUN: on the first rising edge with rst=1.
  - S_RUN: rom_ce_o=1; left only by reset.
- rom_addr_o = pc at all times, combinationally from the register.
- PC update, evaluated at each edge:
  - In S_IDLE: pc holds RESET_PC.
  - In S_RUN, first match in this priority order:
    1. flush_i=1 -> pc <= new_pc_i.
    2. stall_i[0]=1 -> hold.
    3. branch_flag_i=1 -> pc <= branch_target_i.
    4. Otherwise -> pc <= pc+4, modulo 2^ADDR_W (0xFFFFFFFC wraps to 0x00000000).
- Delay slot: the instruction fetched in the same cycle that branch_flag_i is high is captured normally. No squash on branch.
- IF/ID register update, first match in this priority order:
  1. flush_i=1 -> clear to the reset values.
  2. stall_i[1]=1 and stall_i[2]=0 -> insert a bubble (reset values).
  3. stall_i[1]=0 -> capture:
     - id_pc_o <= pc
     - id_valid_o <= rom_ce_o
     - id_adel_o <= rom_ce_o and (pc[1:0] != 0)
     - id_inst_o <= inst_i when rom_ce_o=1 and pc[1:0]=0; otherwise 0.
  4. Otherwise (stall_i[1]=1, stall_i[2]=1) -> hold all id_* outputs.
- Misaligned PC: the ROM is still addressed. After a misaligned fetch the PC keeps sequencing (+4, or branch); recovery comes from the downstream flush.
- Simultaneous events: flush overrides stall and branch in both PC and IF/ID. A branch during stall_i[0]=1 is ignored; ID re-asserts it after the stall.
- Latency: an instruction at PC p reaches id_* one edge after p appears on rom_addr_o.
- Reset asserted mid-operation forces all reset values immediately, without waiting for a clock edge. On release, the design re-enters S_IDLE for one cycle.

Test Plan:
- Reset then release, ROM word k = 0x1000_0000+k -> cycle1 rom_ce_o=1, rom_addr_o=0x0. Following edges: addr 0x4, 0x8. id_pc_o/id_inst_o lag one edge: (0x0, 0x10000000), then (0x4, 0x10000001). id_valid_o=0 until the first capture.
- At pc=0x8, stall_i=6'b000011 for 2 cycles -> pc held at 0x8, id_valid_o=0 (bubble). Then stall_i=6'b000111 -> id_* hold. Release -> pc 0xC, id_pc_o=0x8.
- At pc=0xC, branch_flag_i=1, branch_target_i=0x40 -> next pc=0x40, then 0x44. id_pc_o sequence is 0xC (delay slot), then 0x40.
- flush_i=1 with new_pc_i=0x20, concurrent with branch_flag_i=1 and stall_i=6'b000011 -> pc=0x20, all id_* cleared. Next edge id_pc_o=0x20, id_valid_o=1.
- Misaligned and wrap:
  - branch_target_i=0x42 -> id_pc_o=0x42, id_adel_o=1, id_inst_o=0, id_valid_o=1.
  - flush to 0xFFFFFFFC -> next pc=0x00000000.
- Assert rst low between clock edges during running fetch -> outputs reach reset values before the next edge. After release, one cycle with rom_ce_o=0, then fetch resumes from 0x0.

Source files
------------

// File: rtl/pc_if_stage.sv
// Instruction-fetch front end: PC register, ROM addressing and the IF/ID pipeline register.
// Handles stall, branch redirect, exception flush and misaligned-fetch flagging.
module pc_if_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] new_pc_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic [INST_W-1:0] inst_i,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic              id_adel_o,
    output logic              id_valid_o
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
        logic              adel;
        logic              valid;
    } ifid_t;

    localparam ifid_t IFID_RST = '{pc: '0, inst: '0, adel: 1'b0, valid: 1'b0};

    state_t            state_q, state_nxt;
    logic [ADDR_W-1:0] pc_q, pc_nxt;
    ifid_t             ifid_q, ifid_nxt;
    logic              misaligned;

    // Upper stall bits belong to later stages.
    logic [2:0] unused_stall_bits;
    assign unused_stall_bits = stall_i[5:3];

    assign rom_addr_o = pc_q;
    assign misaligned = |pc_q[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        rom_ce_o  = 1'b0;
        case (state_q)
            S_IDLE: state_nxt = S_RUN;
            S_RUN:  rom_ce_o  = 1'b1;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pc_nxt = pc_q;
        if (state_q == S_IDLE)     pc_nxt = RESET_PC;
        else if (flush_i)          pc_nxt = new_pc_i;
        else if (stall_i[0])       pc_nxt = pc_q;
        else if (branch_flag_i)    pc_nxt = branch_target_i;
        else                       pc_nxt = pc_q + ADDR_W'(4);
    end

    // A misaligned fetch still reaches ID, but with its word zeroed and adel raised.
    always_comb begin
        ifid_nxt = ifid_q;
        if (flush_i) begin
            ifid_nxt = IFID_RST;
        end else if (stall_i[1] && !stall_i[2]) begin
            ifid_nxt = IFID_RST;
        end else if (!stall_i[1]) begin
            ifid_nxt.pc    = pc_q;
            ifid_nxt.valid = rom_ce_o;
            ifid_nxt.adel  = rom_ce_o && misaligned;
            ifid_nxt.inst  = (rom_ce_o && !misaligned) ? inst_i : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q   <= RESET_PC;
            ifid_q <= IFID_RST;
        end else begin
            pc_q   <= pc_nxt;
            ifid_q <= ifid_nxt;
        end
    end

    assign id_pc_o    = ifid_q.pc;
    assign id_inst_o  = ifid_q.inst;
    assign id_adel_o  = ifid_q.adel;
    assign id_valid_o = ifid_q.valid;

endmodule

// File: tb/tb_pc_if_stage.sv
// Scoreboard bench for pc_if_stage: directed test-plan sequence plus randomized
// stall/branch/flush traffic checked against a cycle-level reference model.
module tb_pc_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic [31:0] inst_i;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_adel_o;
    logic        id_valid_o;

    pc_if_stage #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .new_pc_i(new_pc_i), .branch_flag_i(branch_flag_i),
        .branch_target_i(branch_target_i), .inst_i(inst_i),
        .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o), .id_pc_o(id_pc_o),
        .id_inst_o(id_inst_o), .id_adel_o(id_adel_o), .id_valid_o(id_valid_o)
    );

    always #5 clk = ~clk;

    // ROM word k (byte address 4k) = 0x1000_0000 + k
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction
    assign inst_i = rom_word(rom_addr_o);

    typedef struct {
        logic        ce;
        logic [31:0] addr;
        logic [31:0] id_pc;
        logic [31:0] id_inst;
        logic        adel;
        logic        valid;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    bit          m_running;
    logic [31:0] m_pc;
    logic [31:0] m_id_pc, m_id_inst;
    logic        m_adel, m_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_running = 0; m_pc = 32'h0;
        m_id_pc = 0; m_id_inst = 0; m_adel = 0; m_valid = 0;
    endtask

    // One rising edge, using the inputs currently applied.
    task automatic model_step();
        bit          fetching;
        logic [31:0] cur;
        if (!rst) begin
            model_reset();
            return;
        end
        fetching = m_running;
        cur      = m_pc;
        if (flush_i || (stall_i[1] && !stall_i[2])) begin
            m_id_pc = 0; m_id_inst = 0; m_adel = 0; m_valid = 0;
        end else if (!stall_i[1]) begin
            m_id_pc   = cur;
            m_valid   = fetching;
            m_adel    = fetching && (cur % 4 != 0);
            m_id_inst = (fetching && cur % 4 == 0) ? rom_word(cur) : 32'h0;
        end
        if (!m_running)         m_pc = 32'h0;
        else if (flush_i)       m_pc = new_pc_i;
        else if (stall_i[0])    m_pc = m_pc;
        else if (branch_flag_i) m_pc = branch_target_i;
        else                    m_pc = m_pc + 32'd4;
        m_running = 1;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.ce = m_running; e.addr = m_pc; e.id_pc = m_id_pc;
        e.id_inst = m_id_inst; e.adel = m_adel; e.valid = m_valid;
        return e;
    endfunction

    // Called at posedge+1: apply inputs, let the edge happen, queue the expected outputs.
    task automatic drive(input logic [5:0] st, input logic fl, input logic [31:0] npc,
                         input logic br, input logic [31:0] tgt);
        stall_i = st; flush_i = fl; new_pc_i = npc;
        branch_flag_i = br; branch_target_i = tgt;
        @(posedge clk);
        model_step();
        #1;
        exp_q.push_back(model_out());
    endtask

    task automatic nop();
        drive(6'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ce"},    {31'b0, rom_ce_o},   32'h0);
        chk({tag, "_addr"},  rom_addr_o,          32'h0);
        chk({tag, "_idpc"},  id_pc_o,             32'h0);
        chk({tag, "_inst"},  id_inst_o,           32'h0);
        chk({tag, "_adel"},  {31'b0, id_adel_o},  32'h0);
        chk({tag, "_valid"}, {31'b0, id_valid_o}, 32'h0);
    endtask

    // Monitor: compare the DUT against each queued expectation, away from the edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rom_ce",   {31'b0, rom_ce_o},   {31'b0, e.ce});
            chk("rom_addr", rom_addr_o,          e.addr);
            chk("id_pc",    id_pc_o,             e.id_pc);
            chk("id_inst",  id_inst_o,           e.id_inst);
            chk("id_adel",  {31'b0, id_adel_o},  {31'b0, e.adel});
            chk("id_valid", {31'b0, id_valid_o}, {31'b0, e.valid});
        end
    end

    task automatic random_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            logic [5:0]  st;
            logic        fl, br;
            logic [31:0] npc, tgt;
            st  = 6'b0;
            if ($urandom_range(0, 5) == 0) st[0] = 1'b1;
            if ($urandom_range(0, 5) == 0) st[1] = 1'b1;
            if ($urandom_range(0, 3) == 0) st[2] = 1'b1;
            st[5:3] = 3'($urandom);
            fl  = ($urandom_range(0, 19) == 0);
            br  = ($urandom_range(0, 6) == 0);
            npc = $urandom & 32'hFFFF_FFFC;
            tgt = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
            drive(st, fl, npc, br, tgt);
        end
    endtask

    initial begin
        rst = 1'b0;
        stall_i = 0; flush_i = 0; new_pc_i = 0; branch_flag_i = 0; branch_target_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b1;

        // Sequential fetch
        nop(); nop(); nop();
        // Stall PC + IF/ID (bubble), then stall through ID (hold), then release
        drive(6'b000011, 0, 0, 0, 0);
        drive(6'b000011, 0, 0, 0, 0);
        drive(6'b000111, 0, 0, 0, 0);
        nop();
        // Branch with delay slot
        drive(6'b0, 0, 0, 1, 32'h40);
        nop(); nop();
        // Flush beats branch and stall
        drive(6'b000011, 1, 32'h20, 1, 32'h80);
        chk("flush_pc", rom_addr_o, 32'h20);
        nop();
        chk("after_flush_idpc", id_pc_o, 32'h20);
        // Misaligned branch target
        drive(6'b0, 0, 0, 1, 32'h42);
        nop();
        chk("adel_idpc", id_pc_o, 32'h42);
        chk("adel_flag", {31'b0, id_adel_o}, 32'h1);
        chk("adel_inst", id_inst_o, 32'h0);
        nop();
        // PC wrap
        drive(6'b0, 1, 32'hFFFF_FFFC, 0, 0);
        nop();
        chk("wrap_pc", rom_addr_o, 32'h0);
        nop();

        random_cycles(1500);

        // Asynchronous reset between edges
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async");
        exp_q.delete();
        model_reset();
        exp_q.push_back(model_out());
        nop();
        #1;
        rst = 1'b1;
        #1;
        chk("idle_ce", {31'b0, rom_ce_o}, 32'h0);
        nop();
        chk("resume_addr", rom_addr_o, 32'h0);
        chk("resume_ce", {31'b0, rom_ce_o}, 32'h1);
        nop();

        random_cycles(1500);

        // Bounded drain of the scoreboard
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
